// File: rtl/image_proc_sequencer.sv
// Job controller beside the ImageProcessor datapath. It hands image RAM to the HPS on demand,
// runs and flushes processing jobs, and reports job status and counters.
module image_proc_sequencer #(
  parameter int MODE_W    = 3,
  parameter int FLUSH_LAT = 2,
  parameter int TIMEOUT_W = 20,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [MODE_W-1:0] mode_in,
  input  logic              hps_writing_image,
  input  logic              abort,
  input  logic              done,
  output logic              enable,
  output logic              wren,
  output logic              hps_grant,
  output logic              busy,
  output logic [MODE_W-1:0] mode_q,
  output logic              job_done,
  output logic              timeout_err,
  output logic              processing_has_run_once,
  output logic [CNT_W-1:0]  job_count
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PROCESS = 3'd1;
  localparam logic [2:0] S_FLUSH   = 3'd2;
  localparam logic [2:0] S_MEMORY  = 3'd3;
  localparam logic [2:0] S_ERROR   = 3'd4;

  localparam int             FL_W    = (FLUSH_LAT > 1) ? $clog2(FLUSH_LAT) : 1;
  localparam logic [FL_W-1:0] FL_LAST = FL_W'(FLUSH_LAT - 1);

  logic [2:0]           r_state;
  logic                 r_pending;
  logic [MODE_W-1:0]    r_pend_mode;
  logic [TIMEOUT_W-1:0] r_wd;
  logic [FL_W-1:0]      r_fcnt;
  logic                 r_enable;
  logic                 r_wren;
  logic                 r_hps_grant;
  logic                 r_busy;
  logic [MODE_W-1:0]    r_mode_q;
  logic                 r_job_done;
  logic                 r_timeout_err;
  logic                 r_has_run;
  logic [CNT_W-1:0]     r_job_count;

  logic [2:0]           w_next;
  logic                 w_accept;
  logic                 w_complete;
  logic [TIMEOUT_W-1:0] w_wd_next;
  logic [FL_W-1:0]      w_fcnt_next;

  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_complete  = 1'b0;
    w_wd_next   = r_wd;
    w_fcnt_next = r_fcnt;
    case (r_state)
      S_IDLE: begin
        if (!hps_writing_image && (start || r_pending)) begin
          w_next    = S_PROCESS;
          w_accept  = 1'b1;
          w_wd_next = '0;
        end
      end
      S_PROCESS: begin
        w_wd_next = r_wd + 1'b1;
        if (abort) begin
          w_next = S_IDLE;
        end else if (done) begin
          w_next      = S_FLUSH;
          w_fcnt_next = '0;
        end else if (w_wd_next == '1) begin
          w_next = S_ERROR;
        end
      end
      S_FLUSH: begin
        if (abort) begin
          w_next = S_IDLE;
        end else if (r_fcnt == FL_LAST) begin
          w_next     = S_IDLE;
          w_complete = 1'b1;
        end else begin
          w_fcnt_next = r_fcnt + 1'b1;
        end
      end
      S_MEMORY: begin
        if (!hps_writing_image) w_next = S_IDLE;
      end
      S_ERROR: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
    // HPS ownership overrides everything; a done landing in the same cycle still counts.
    if (hps_writing_image) begin
      w_next     = S_MEMORY;
      w_complete = (r_state == S_PROCESS) && done && !abort;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_pending     <= 1'b0;
      r_pend_mode   <= '0;
      r_wd          <= '0;
      r_fcnt        <= '0;
      r_enable      <= 1'b0;
      r_wren        <= 1'b0;
      r_hps_grant   <= 1'b0;
      r_busy        <= 1'b0;
      r_mode_q      <= '0;
      r_job_done    <= 1'b0;
      r_timeout_err <= 1'b0;
      r_has_run     <= 1'b0;
      r_job_count   <= '0;
    end else begin
      r_state     <= w_next;
      r_wd        <= w_wd_next;
      r_fcnt      <= w_fcnt_next;
      r_enable    <= (w_next == S_PROCESS);
      r_wren      <= (w_next == S_PROCESS) || (w_next == S_FLUSH);
      r_hps_grant <= (w_next == S_MEMORY);
      r_busy      <= (w_next == S_PROCESS) || (w_next == S_FLUSH);
      r_job_done  <= w_complete;

      if (w_complete) begin
        r_has_run <= 1'b1;
        if (r_job_count != '1) r_job_count <= r_job_count + 1'b1;
      end

      if (w_accept) begin
        r_mode_q      <= start ? mode_in : r_pend_mode;
        r_timeout_err <= 1'b0;
      end else if (w_next == S_ERROR) begin
        r_timeout_err <= 1'b1;
      end

      // One-deep start queue: newest request wins, abort discards it.
      if (w_accept) begin
        r_pending <= 1'b0;
      end else if (abort) begin
        r_pending <= 1'b0;
      end else if (start) begin
        r_pending   <= 1'b1;
        r_pend_mode <= mode_in;
      end
    end
  end

  assign enable                  = r_enable;
  assign wren                    = r_wren;
  assign hps_grant               = r_hps_grant;
  assign busy                    = r_busy;
  assign mode_q                  = r_mode_q;
  assign job_done                = r_job_done;
  assign timeout_err             = r_timeout_err;
  assign processing_has_run_once = r_has_run;
  assign job_count               = r_job_count;

endmodule

// File: tb/tb_image_proc_sequencer.sv
// Scoreboard bench for image_proc_sequencer: directed job scenarios followed by random traffic,
// each cycle compared against a job-level reference model.
module tb_image_proc_sequencer;
  localparam int MODE_W    = 3;
  localparam int FLUSH_LAT = 2;
  localparam int TIMEOUT_W = 4;
  localparam int CNT_W     = 2;
  localparam int WD_LIMIT  = (1 << TIMEOUT_W) - 1;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset, start, hps_writing_image, abort, done;
  logic [MODE_W-1:0] mode_in, mode_q;
  logic enable, wren, hps_grant, busy, job_done, timeout_err, processing_has_run_once;
  logic [CNT_W-1:0] job_count;

  image_proc_sequencer #(
    .MODE_W(MODE_W), .FLUSH_LAT(FLUSH_LAT), .TIMEOUT_W(TIMEOUT_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mode_in(mode_in),
    .hps_writing_image(hps_writing_image), .abort(abort), .done(done),
    .enable(enable), .wren(wren), .hps_grant(hps_grant), .busy(busy), .mode_q(mode_q),
    .job_done(job_done), .timeout_err(timeout_err),
    .processing_has_run_once(processing_has_run_once), .job_count(job_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              en;
    logic              wr;
    logic              gr;
    logic              bz;
    logic              jd;
    logic              te;
    logic              hr;
    logic [MODE_W-1:0] md;
    logic [CNT_W-1:0]  cnt;
  } obs_t;

  obs_t sb[$];
  int checks = 0;
  int errors = 0;

  // Reference model: where the job is, how long it has run, how much drain is left.
  typedef enum int {PH_IDLE, PH_RUN, PH_DRAIN, PH_HOST, PH_FAULT} phase_t;
  phase_t            ph;
  int                run_cycles, drain_left, m_cnt;
  bit                pend, m_terr, m_ran;
  logic [MODE_W-1:0] pmode, m_mode;

  task automatic model_reset();
    ph = PH_IDLE; run_cycles = 0; drain_left = 0; m_cnt = 0;
    pend = 0; m_terr = 0; m_ran = 0; pmode = '0; m_mode = '0;
  endtask

  task automatic model_step(input bit s, input logic [MODE_W-1:0] md, input bit h,
                            input bit a, input bit d);
    phase_t nxt;
    bit     fin, acc;
    obs_t   e;
    nxt = ph; fin = 0; acc = 0;
    if (h) begin
      fin = (ph == PH_RUN) && d && !a;
      nxt = PH_HOST;
    end else begin
      case (ph)
        PH_IDLE: if (s || pend) begin
          nxt = PH_RUN; acc = 1; run_cycles = 0;
          m_mode = s ? md : pmode; m_terr = 0;
        end
        PH_RUN: begin
          if (a) nxt = PH_IDLE;
          else if (d) begin nxt = PH_DRAIN; drain_left = FLUSH_LAT; end
          else begin
            run_cycles++;
            if (run_cycles >= WD_LIMIT) begin nxt = PH_FAULT; m_terr = 1; end
          end
        end
        PH_DRAIN: begin
          if (a) nxt = PH_IDLE;
          else begin
            drain_left--;
            if (drain_left == 0) begin nxt = PH_IDLE; fin = 1; end
          end
        end
        default: nxt = PH_IDLE;
      endcase
    end
    if (acc) pend = 0;
    else if (a) pend = 0;
    else if (s) begin pend = 1; pmode = md; end
    if (fin) begin
      m_ran = 1;
      if (m_cnt < CNT_MAX) m_cnt++;
    end
    ph = nxt;
    e.en  = (ph == PH_RUN);
    e.wr  = (ph == PH_RUN) || (ph == PH_DRAIN);
    e.gr  = (ph == PH_HOST);
    e.bz  = e.wr;
    e.jd  = fin;
    e.te  = m_terr;
    e.hr  = m_ran;
    e.md  = m_mode;
    e.cnt = CNT_W'(m_cnt);
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    obs_t e, a;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      a = '{enable, wren, hps_grant, busy, job_done, timeout_err,
            processing_has_run_once, mode_q, job_count};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL scoreboard t=%0t: got en%b wr%b gr%b bz%b jd%b te%b hr%b md%0d cnt%0d required en%b wr%b gr%b bz%b jd%b te%b hr%b md%0d cnt%0d",
                 $time, a.en, a.wr, a.gr, a.bz, a.jd, a.te, a.hr, a.md, a.cnt,
                 e.en, e.wr, e.gr, e.bz, e.jd, e.te, e.hr, e.md, e.cnt);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic cycle(input bit s = 0, input logic [MODE_W-1:0] md = '0, input bit h = 0,
                       input bit a = 0, input bit d = 0);
    @(negedge clk);
    start = s; mode_in = md; hps_writing_image = h; abort = a; done = d;
    @(posedge clk);
    model_step(s, md, h, a, d);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic check_all_zero(input string name);
    chk(name, int'({enable, wren, hps_grant, busy, job_done, timeout_err,
                    processing_has_run_once, mode_q, job_count}), 0);
  endtask

  task automatic async_reset();
    @(negedge clk);
    start = 0; hps_writing_image = 0; abort = 0; done = 0; mode_in = '0;
    #2 reset = 1'b1;
    #1 check_all_zero("async_reset_outputs");
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 0; mode_in = '0; hps_writing_image = 0; abort = 0; done = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset_outputs");
    @(negedge clk);
    reset = 1'b0;

    // Basic job: mode 3, done after 10 PROCESS cycles, 2-cycle flush.
    cycle(1, 3);
    chk("t1_enable", int'(enable), 1);
    idle(9);
    chk("t1_wren_process", int'(wren), 1);
    cycle(0, 0, 0, 0, 1);
    chk("t1_flush_enable", int'(enable), 0);
    chk("t1_flush_wren", int'(wren), 1);
    idle(1);
    chk("t1_flush_wren2", int'(wren), 1);
    idle(1);
    chk("t1_job_done", int'(job_done), 1);
    chk("t1_job_count", int'(job_count), 1);
    chk("t1_has_run", int'(processing_has_run_once), 1);
    chk("t1_mode_q", int'(mode_q), 3);
    chk("t1_wren_off", int'(wren), 0);

    // HPS preempts a running job.
    cycle(1, 2);
    idle(3);
    cycle(0, 0, 1);
    chk("t2_grant", int'(hps_grant), 1);
    chk("t2_enable", int'(enable), 0);
    for (int k = 0; k < 4; k++) cycle(0, 0, 1);
    cycle();
    chk("t2_grant_off", int'(hps_grant), 0);
    chk("t2_count_kept", int'(job_count), 1);
    chk("t2_no_done", int'(job_done), 0);

    async_reset();

    // Queued starts: last one wins, only one extra job.
    cycle(1, 4);
    chk("t3_mode_first", int'(mode_q), 4);
    idle(2);
    cycle(1, 1);
    idle(2);
    cycle(0, 0, 0, 0, 1);
    cycle(1, 5);
    cycle();
    chk("t3_job_done", int'(job_done), 1);
    cycle();
    chk("t3_queued_mode", int'(mode_q), 5);
    chk("t3_queued_enable", int'(enable), 1);
    idle(3);
    cycle(0, 0, 0, 0, 1);
    idle(2);
    chk("t3_count", int'(job_count), 2);
    idle(3);
    chk("t3_no_third_job", int'(enable), 0);

    // Watchdog timeout.
    cycle(1, 6);
    idle(14);
    chk("t4_still_running", int'(enable), 1);
    idle(1);
    chk("t4_timeout_err", int'(timeout_err), 1);
    chk("t4_error_enable", int'(enable), 0);
    idle(1);
    chk("t4_err_sticky", int'(timeout_err), 1);
    cycle(1, 2);
    chk("t4_err_cleared", int'(timeout_err), 0);
    idle(2);
    cycle(0, 0, 0, 1);
    chk("t6_abort_idle", int'(busy), 0);
    idle(2);
    chk("t6_abort_no_count", int'(job_count), 2);

    // done together with hps write: counts, skips flush.
    cycle(1, 7);
    idle(3);
    cycle(0, 0, 1, 0, 1);
    chk("t5_job_done", int'(job_done), 1);
    chk("t5_count", int'(job_count), 3);
    chk("t5_grant", int'(hps_grant), 1);
    chk("t5_no_flush", int'(wren), 0);
    cycle(0, 0, 1);
    cycle();

    // Counter saturation.
    cycle(1, 1);
    idle(2);
    cycle(0, 0, 0, 0, 1);
    idle(2);
    chk("t6_sat_done", int'(job_done), 1);
    chk("t6_sat_count", int'(job_count), 3);

    // Random traffic with one asynchronous reset in the middle.
    begin
      int hps_left;
      hps_left = 0;
      for (int i = 0; i < 3000; i++) begin
        bit s, h, a, d;
        logic [MODE_W-1:0] m;
        if (i == 1500) async_reset();
        if (hps_left == 0 && $urandom_range(0, 99) < 3) hps_left = $urandom_range(1, 6);
        h = (hps_left > 0);
        if (hps_left > 0) hps_left--;
        s = ($urandom_range(0, 99) < 12);
        a = ($urandom_range(0, 99) < 3);
        d = ($urandom_range(0, 99) < 10);
        m = MODE_W'($urandom);
        cycle(s, m, h, a, d);
      end
    end

    cycle();
    @(negedge clk);
    #1 chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
